// File: rtl/writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter_if
// Brief    : X__W execute-to-writeback bundle plus register-file write port
//            and commit trace outputs of the writeback arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface writeback_arbiter_if #(
    parameter int p_data_bits = 32,
    parameter int p_num_pipes = 2
);
    logic [p_num_pipes-1:0]             X_val;
    logic [p_num_pipes-1:0]             X_rdy;
    logic [5*p_num_pipes-1:0]           X_waddr;
    logic [p_data_bits*p_num_pipes-1:0] X_wdata;
    logic [p_num_pipes-1:0]             X_wen;

    logic                               rf_wen;
    logic [4:0]                         rf_waddr;
    logic [p_data_bits-1:0]             rf_wdata;
    logic                               commit_val;
    logic [2:0]                         commit_pipe;
    logic [31:0]                        commit_count;

    // Upstream execute pipes plus downstream observers of the write port
    modport master (
        output X_val, X_waddr, X_wdata, X_wen,
        input  X_rdy,
        input  rf_wen, rf_waddr, rf_wdata,
        input  commit_val, commit_pipe, commit_count
    );

    modport slave (
        input  X_val, X_waddr, X_wdata, X_wen,
        output X_rdy,
        output rf_wen, rf_waddr, rf_wdata,
        output commit_val, commit_pipe, commit_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : writeback_arbiter
// Brief    : Round-robin arbiter over execute pipes feeding a registered
//            register-file write port and commit counter.
// Revision : 1.0  initial release
// ============================================================================
module writeback_arbiter #(
    parameter int p_data_bits = 32,
    parameter int p_num_pipes = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    writeback_arbiter_if.slave    wb
);

    localparam int c_IDX_W = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    logic [c_IDX_W-1:0]     w_ptr;
    logic [c_IDX_W-1:0]     w_grant_idx;
    logic                   w_grant_any;
    logic                   w_fire;
    logic [p_num_pipes-1:0] w_rdy;
    logic [4:0]             w_sel_waddr;
    logic [p_data_bits-1:0] w_sel_wdata;
    logic                   w_sel_wen;

    logic                   r_rf_wen;
    logic [4:0]             r_rf_waddr;
    logic [p_data_bits-1:0] r_rf_wdata;
    logic                   r_commit_val;
    logic [2:0]             r_commit_pipe;
    logic [31:0]            r_commit_count;

    // First valid pipe at or after the pointer, wrapping around
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_sel_waddr = '0;
        w_sel_wdata = '0;
        w_sel_wen   = 1'b0;
        for (int k = 0; k < p_num_pipes; k++) begin
            idx = int'(w_ptr) + k;
            if (idx >= p_num_pipes) begin
                idx = idx - p_num_pipes;
            end
            if (!w_grant_any && wb.X_val[idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = idx[c_IDX_W-1:0];
                w_sel_waddr = wb.X_waddr[idx*5 +: 5];
                w_sel_wdata = wb.X_wdata[idx*p_data_bits +: p_data_bits];
                w_sel_wen   = wb.X_wen[idx];
            end
        end
    end

    assign w_fire = w_grant_any & ~rst;

    always_comb begin
        w_rdy = '0;
        if (w_fire) begin
            w_rdy[w_grant_idx] = 1'b1;
        end
    end

    generate
        if (p_num_pipes == 1) begin : g_ptr_single
            assign w_ptr = '0;
        end else begin : g_ptr_rr
            logic [c_IDX_W-1:0] r_ptr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_fire) begin
                    if (w_grant_idx == c_IDX_W'(p_num_pipes - 1)) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= w_grant_idx + 1'b1;
                    end
                end
            end

            assign w_ptr = r_ptr;
        end
    endgenerate

    // Address and data hold on idle cycles; only the strobes drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wen       <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_commit_val   <= 1'b0;
            r_commit_pipe  <= '0;
            r_commit_count <= '0;
        end else if (w_fire) begin
            r_rf_wen       <= w_sel_wen && (w_sel_waddr != 5'd0);
            r_rf_waddr     <= w_sel_waddr;
            r_rf_wdata     <= w_sel_wdata;
            r_commit_val   <= 1'b1;
            r_commit_pipe  <= 3'(w_grant_idx);
            r_commit_count <= r_commit_count + 32'd1;
        end else begin
            r_rf_wen       <= 1'b0;
            r_commit_val   <= 1'b0;
        end
    end

    assign wb.X_rdy        = w_rdy;
    assign wb.rf_wen       = r_rf_wen;
    assign wb.rf_waddr     = r_rf_waddr;
    assign wb.rf_wdata     = r_rf_wdata;
    assign wb.commit_val   = r_commit_val;
    assign wb.commit_pipe  = r_commit_pipe;
    assign wb.commit_count = r_commit_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_arbiter
// Brief    : Self-checking bench for writeback_arbiter against a behavioural
//            round-robin model.
// Revision : 1.0  initial release
// ============================================================================
module tb_writeback_arbiter;

    localparam int c_N = 2;
    localparam int c_D = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    writeback_arbiter_if #(.p_data_bits(c_D), .p_num_pipes(c_N)) wb ();

    writeback_arbiter #(.p_data_bits(c_D), .p_num_pipes(c_N)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    int checks   = 0;
    int failures = 0;

    int          m_ptr;
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_cval;
    logic [2:0]  m_cpipe;
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_pipe(input int p, input logic v, input logic [4:0] a,
                            input logic [31:0] d, input logic e);
        wb.X_val[p]             = v;
        wb.X_waddr[5*p +: 5]    = a;
        wb.X_wdata[c_D*p +: c_D] = d;
        wb.X_wen[p]             = e;
    endtask

    task automatic clear_pipes();
        for (int p = 0; p < c_N; p++) set_pipe(p, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    // Called just after a rising edge with inputs already applied; returns the granted pipe or -1
    task automatic cycle(output int g);
        logic [c_N-1:0] exp_rdy;
        int             idx;
        #1;
        g = -1;
        for (int k = 0; k < c_N; k++) begin
            idx = (m_ptr + k) % c_N;
            if (g < 0 && wb.X_val[idx]) g = idx;
        end
        exp_rdy = '0;
        if (!rst && g >= 0) exp_rdy[g] = 1'b1;
        check("x_rdy", 64'(wb.X_rdy), 64'(exp_rdy));

        if (rst) begin
            g       = -1;
            m_ptr   = 0;
            m_wen   = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_cval  = 1'b0;
            m_cpipe = '0;
            m_count = '0;
        end else if (g >= 0) begin
            m_waddr = wb.X_waddr[5*g +: 5];
            m_wdata = wb.X_wdata[c_D*g +: c_D];
            m_wen   = wb.X_wen[g] && (m_waddr != 5'd0);
            m_cval  = 1'b1;
            m_cpipe = 3'(g);
            m_count = m_count + 32'd1;
            m_ptr   = (g + 1) % c_N;
        end else begin
            m_wen  = 1'b0;
            m_cval = 1'b0;
        end

        @(posedge clk);
        #1;
        check("rf_wen",       64'(wb.rf_wen),       64'(m_wen));
        check("rf_waddr",     64'(wb.rf_waddr),     64'(m_waddr));
        check("rf_wdata",     64'(wb.rf_wdata),     64'(m_wdata));
        check("commit_val",   64'(wb.commit_val),   64'(m_cval));
        check("commit_pipe",  64'(wb.commit_pipe),  64'(m_cpipe));
        check("commit_count", 64'(wb.commit_count), 64'(m_count));
    endtask

    task automatic do_reset();
        int g;
        rst = 1'b1;
        cycle(g);
        cycle(g);
        rst = 1'b0;
    endtask

    initial begin
        int          g;
        int          rem  [c_N];
        int          idle [c_N];
        bit          hold [c_N];
        int          obs  [c_N];
        int          cyc;

        rst     = 1'b1;
        wb.X_val   = '0;
        wb.X_waddr = '0;
        wb.X_wdata = '0;
        wb.X_wen   = '0;
        m_ptr   = 0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_cval  = 1'b0;
        m_cpipe = '0;
        m_count = '0;

        @(posedge clk);
        #1;
        do_reset();

        // Single pipe, single transaction
        set_pipe(0, 1'b1, 5'd1, 32'd2, 1'b1);
        cycle(g);
        check("single_grant", 64'(g), 64'(0));
        check("single_count", 64'(wb.commit_count), 64'd1);
        clear_pipes();
        cycle(g);

        // Contention from a fresh pointer
        do_reset();
        set_pipe(0, 1'b1, 5'd3, 32'hA, 1'b1);
        set_pipe(1, 1'b1, 5'd4, 32'hB, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(g);
            check("contend_waddr", 64'(wb.rf_waddr), (i % 2 == 0) ? 64'd3 : 64'd4);
        end
        check("contend_count", 64'(wb.commit_count), 64'd4);
        clear_pipes();
        cycle(g);

        // x0 write and wen=0 both commit without a register write
        set_pipe(1, 1'b1, 5'd0, 32'hFF, 1'b1);
        cycle(g);
        check("x0_wen", 64'(wb.rf_wen), 64'd0);
        set_pipe(1, 1'b1, 5'd5, 32'h55, 1'b0);
        cycle(g);
        check("nowen_val", 64'(wb.commit_val), 64'd1);
        check("nowen_count", 64'(wb.commit_count), 64'd6);
        clear_pipes();
        cycle(g);

        // Random traffic, 20 transactions per pipe
        do_reset();
        for (int p = 0; p < c_N; p++) begin
            rem[p]  = 20;
            idle[p] = int'($urandom_range(0, 3));
            hold[p] = 1'b0;
            obs[p]  = 0;
        end
        cyc = 0;
        while ((rem[0] > 0 || rem[1] > 0) && cyc < 2000) begin
            for (int p = 0; p < c_N; p++) begin
                if (!hold[p]) begin
                    if (idle[p] > 0) begin
                        idle[p]--;
                        set_pipe(p, 1'b0, 5'd0, 32'd0, 1'b0);
                    end else if (rem[p] > 0) begin
                        hold[p] = 1'b1;
                        set_pipe(p, 1'b1, 5'($urandom), $urandom, 1'($urandom));
                    end else begin
                        set_pipe(p, 1'b0, 5'd0, 32'd0, 1'b0);
                    end
                end
            end
            cycle(g);
            if (g >= 0) begin
                hold[g] = 1'b0;
                rem[g]--;
                idle[g] = int'($urandom_range(0, 3));
            end
            if (wb.commit_val && wb.commit_pipe < 3'(c_N)) obs[wb.commit_pipe]++;
            cyc++;
        end
        check("rand_done", 64'(cyc < 2000), 64'd1);
        check("rand_pipe0", 64'(obs[0]), 64'd20);
        check("rand_pipe1", 64'(obs[1]), 64'd20);
        check("rand_total", 64'(wb.commit_count), 64'd40);
        clear_pipes();
        cycle(g);

        // Reset right after a fire from pipe 0 (pointer would otherwise favour pipe 1)
        set_pipe(0, 1'b1, 5'd7, 32'h77, 1'b1);
        cycle(g);
        set_pipe(1, 1'b1, 5'd8, 32'h88, 1'b1);
        rst = 1'b1;
        cycle(g);
        check("rst_wen", 64'(wb.rf_wen), 64'd0);
        check("rst_count", 64'(wb.commit_count), 64'd0);
        rst = 1'b0;
        cycle(g);
        check("rst_first_grant", 64'(wb.commit_pipe), 64'd0);
        clear_pipes();
        cycle(g);

        // Counter wrap
        force dut.r_commit_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_commit_count;
        m_count = 32'hFFFF_FFFF;
        set_pipe(1, 1'b1, 5'd9, 32'h99, 1'b1);
        cycle(g);
        check("wrap_count", 64'(wb.commit_count), 64'd0);
        clear_pipes();
        cycle(g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that sits directly downstream of the execute units (ALU, multiplier, …) and consumes their X__W transactions. It round-robin arbitrates among `p_num_pipes` execute pipes, accepts at most one transaction per cycle, and drives a registered register-file write port one cycle later. It also produces a commit pulse and a running commit count for the core's trace and performance logic.

## Interface
- `p_data_bits`, 32, width of `wdata` and of the register-file data.
- `p_num_pipes`, 2, number of upstream execute pipes. Legal range is 1 to 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `X_val`  in  `p_num_pipes`  per-pipe X__W valid.
- `X_rdy`  out  `p_num_pipes`  per-pipe X__W ready; combinational.
- `X_waddr`  in  `5*p_num_pipes`  per-pipe destination register. Pipe i occupies bits [5i+4:5i].
- `X_wdata`  in  `p_data_bits*p_num_pipes`  per-pipe result. Same packing as `X_waddr`.
- `X_wen`  in  `p_num_pipes`  per-pipe write enable.
- `rf_wen`  out  1  register-file write enable; registered.
- `rf_waddr`  out  5  register-file write address; registered.
- `rf_wdata`  out  `p_data_bits`  register-file write data; registered.
- `commit_val`  out  1  one-cycle pulse for each committed transaction; registered.
- `commit_pipe`  out  3  index of the pipe that committed; registered.
- `commit_count`  out  32  total committed transactions; wraps modulo 2^32.

## Operation
**Handshake.** A transaction on pipe i fires when `X_val[i] && X_rdy[i]`. The block never stalls downstream, so whenever any `X_val` is high exactly one `X_rdy` is high.

**Arbitration.** A round-robin pointer `ptr` selects the highest-priority pipe.
- Grant goes to the first pipe with `X_val` high, searching `ptr`, `ptr+1`, … modulo `p_num_pipes`.
- `X_rdy[g]` = 1 only for the granted pipe g; all other `X_rdy` bits are 0.
- When a transaction fires, `ptr` ← (g+1) mod `p_num_pipes`.
- When nothing fires, `ptr` holds.
- `X_rdy` does not depend on the previous `X_rdy`. It depends only on the current `X_val` and `ptr`.

**Write stage register.** On a fire from pipe g:
- `rf_waddr` ← `X_waddr[g]` and `rf_wdata` ← `X_wdata[g]`.
- `rf_wen` ← `X_wen[g] && (X_waddr[g] != 0)`. Writes to x0 are suppressed, but the transaction still commits.
- `commit_val` ← 1 and `commit_pipe` ← g.
- `commit_count` ← `commit_count` + 1.

On a cycle with no fire:
- `rf_wen` ← 0 and `commit_val` ← 0.
- `rf_waddr`, `rf_wdata` and `commit_pipe` hold their previous values.

**Degenerate width.** With `p_num_pipes` = 1, `ptr` is constant 0 and `X_rdy[0]` = `X_val[0]`.

**Reset.** While `rst` = 1 at a clock edge:
- `ptr`, `rf_wen`, `rf_waddr`, `rf_wdata`, `commit_val`, `commit_pipe` and `commit_count` all become 0.
- All `X_rdy` are forced to 0 combinationally while `rst` is high, so no transaction fires during reset.
- A write that was staged when reset arrives is dropped: `rf_wen` is 0 in the cycle after the reset edge.

## Timing
- Latency: a fire in cycle N appears on `rf_*` and `commit_*` in cycle N+1, and `commit_count` is updated in cycle N+1.
- Throughput: one transaction per cycle.
  - A single pipe holding `X_val` continuously commits every cycle.
  - With all pipes valid, grants rotate 0, 1, …, N-1, 0, …
- Simultaneous valid on several pipes: only the granted pipe fires. The others must hold `val` and their message stable until accepted, per the val/rdy protocol.
- `commit_count` wraps from 0xFFFFFFFF to 0 with no flag.
- Valid outputs in the first cycle after reset deasserts: none; `rf_wen` = 0.
  - A fire in that first cycle appears in the following cycle.

## Test plan
- **Single pipe, single transaction.** Pipe 0 sends waddr=1, wdata=2, wen=1. The next cycle shows `rf_wen`=1, `rf_waddr`=1, `rf_wdata`=2, `commit_pipe`=0, `commit_count`=1.
- **Contention.** `p_num_pipes`=2, both pipes valid and held for 4 cycles: pipe 0 waddr=3 data=0xA, pipe 1 waddr=4 data=0xB. Grants alternate 0,1,0,1. `rf_waddr` sequence is 3,4,3,4 and `commit_count` reaches 4.
- **x0 and wen=0.** Pipe 1 sends waddr=0, data=0xFF, wen=1, then waddr=5, wen=0. Both produce `commit_val`=1 and `rf_wen`=0; `commit_count` increments by 2.
- **Random delays.** Two pipes each inject 20 random transactions with 0–3 idle cycles between sends. The committed stream matches each pipe's send order, and the total is 40 commits with no drops or duplicates.
- **Reset mid-operation.** Assert `rst` in the cycle after a fire. The next cycle shows `rf_wen`=0, `commit_count`=0, `X_rdy`=0 during reset, and `ptr`=0 afterwards (pipe 0 wins the first contention).
- **Wrap.** Force `commit_count` to 0xFFFFFFFF, then commit once: the count reads 0.
